instr_fetch_unit: RTL

- Upstream neighbour of the multi-cycle control sequencer.
- Holds the PC and computes next-PC from PCSrc/PCWre.
- Fetches the instruction word from instruction memory through a req/ack handshake and latches it into the IR when IRWre is high.
- Decodes the IR fields, including opCode, for the control sequencer and datapath. Stalls the sequencer with fetch_busy while memory is slow.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_req   : read request (fetch unit -> memory)
//   imem_addr  : word-aligned read address (fetch unit -> memory)
//   imem_rdata : instruction word (memory -> fetch unit)
//   imem_ack   : read data valid; may assert in the same cycle as imem_req
// modport master : fetch-unit side
// modport slave  : memory side
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, computes next-PC, fetches the
// instruction word over a req/ack memory bus into the IR and decodes the IR
// fields for the control sequencer and datapath.
// Ports:
//   CLK, Reset        : clock, synchronous active-high reset
//   PCWre, PCSrc      : PC write enable / next-PC select (00 +4, 01 branch,
//                       10 jr, 11 jump)
//   IRWre             : fetch request from the sequencer
//   immExt, rsData    : branch immediate, jr target
//   imem              : instruction memory bus (master side)
//   PC, PC4, IR       : current PC, PC+4, instruction register
//   opCode..addr26    : decoded IR fields
//   fetch_busy        : stall while a request is outstanding without ack
//   fetch_err         : sticky misaligned-fetch flag
//   halted            : IR opcode is 6'b111111
//   fetch_cnt         : number of IR loads (wraps)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 PCWre,
    input  logic [1:0]           PCSrc,
    input  logic                 IRWre,
    input  logic [31:0]          immExt,
    input  logic [31:0]          rsData,
    instr_fetch_unit_if.master   imem,
    output logic [31:0]          PC,
    output logic [31:0]          PC4,
    output logic [31:0]          IR,
    output logic [5:0]           opCode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           sa,
    output logic [15:0]          imm16,
    output logic [25:0]          addr26,
    output logic                 fetch_busy,
    output logic                 fetch_err,
    output logic                 halted,
    output logic [CNT_W-1:0]     fetch_cnt
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             req;
    logic             ir_load;
    logic             err_set;

    assign PC4 = pc_q + 32'd4;

    always_comb begin
        pc_d = PC4;
        unique case (PCSrc)
            2'b00: pc_d = PC4;
            2'b01: pc_d = PC4 + {immExt[29:0], 2'b00};
            2'b10: pc_d = rsData;
            2'b11: pc_d = {PC4[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        ir_load = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (IRWre) begin
                    if (pc_q[1:0] == 2'b00) begin
                        req = 1'b1;
                        // Zero-wait memory completes without leaving IDLE.
                        if (imem.imem_ack) ir_load = 1'b1;
                        else               state_d = WAIT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign fetch_busy     = req & ~imem.imem_ack;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // PC must stay put while a fetch of the current PC is outstanding.
            if (PCWre && !fetch_busy) pc_q <= pc_d;
            if (ir_load) begin
                ir_q  <= imem.imem_rdata;
                cnt_q <= cnt_q + 1'b1;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign PC        = pc_q;
    assign IR        = ir_q;
    assign opCode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign sa        = ir_q[10:6];
    assign imm16     = ir_q[15:0];
    assign addr26    = ir_q[25:0];
    assign halted    = (ir_q[31:26] == 6'b111111);
    assign fetch_err = err_q;
    assign fetch_cnt = cnt_q;

endmodule
